// File: rtl/ge_frombytes_vartime_p.sv
// Ed25519 point decompression (ref10 ge_frombytes / ge_frombytes_negate_vartime).
// Field work is farmed out to one shared multiplier, an add unit, a sub unit and
// a pow22523 engine; this block sequences them, does the sign fix-up and the
// zero/parity tests locally, and guards every wait with a watchdog.
module ge_frombytes_vartime_p #(
  parameter int              FE_W         = 320,
  parameter logic [FE_W-1:0] D_CONST      = 320'hff480db4fee2b700ffce7199ffa03cbcff79e8980001c029006a0a0fff156ebd00d37285ff5978b6,
  parameter logic [FE_W-1:0] SQRTM1_CONST = 320'h00ae0c920004fc1effe1656afe804c9ffffbd7a700bd0c600035697f008f189eff86c9d3fe0ea0b0,
  parameter int              MUL_TIMEOUT  = 1024,
  parameter int              POW_TIMEOUT  = 65535
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic            negate_i,
  input  logic [255:0]    s_i,
  output logic            ready_o,
  output logic            done_o,
  output logic [1:0]      error_o,
  output logic [FE_W-1:0] h_x_o,
  output logic [FE_W-1:0] h_y_o,
  output logic [FE_W-1:0] h_z_o,
  output logic [FE_W-1:0] h_t_o,
  output logic [FE_W-1:0] mul_op_a_o,
  output logic [FE_W-1:0] mul_op_b_o,
  output logic            mul_valid_o,
  input  logic [FE_W-1:0] mul_res_i,
  input  logic            mul_done_i,
  output logic [FE_W-1:0] add_op_a_o,
  output logic [FE_W-1:0] add_op_b_o,
  input  logic [FE_W-1:0] add_res_i,
  output logic [FE_W-1:0] sub_op_a_o,
  output logic [FE_W-1:0] sub_op_b_o,
  input  logic [FE_W-1:0] sub_res_i,
  output logic [FE_W-1:0] pow_in_o,
  output logic            pow_valid_o,
  input  logic [FE_W-1:0] pow_res_i,
  input  logic            pow_done_i
);

  // Limb layout: 10 signed 32-bit limbs, alternating 26/25-bit radix.
  localparam int NL = 10;
  localparam int WD_W = $clog2(POW_TIMEOUT + 1);
  localparam logic [WD_W-1:0] MUL_LIM = WD_W'(MUL_TIMEOUT - 1);
  localparam logic [WD_W-1:0] POW_LIM = WD_W'(POW_TIMEOUT - 1);
  localparam logic [FE_W-1:0] FE_ONE = FE_W'(1);
  localparam logic [1:0] ERR_OK = 2'd0, ERR_CURVE = 2'd1, ERR_TO = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE, S_CAP, S_MUL, S_MWAIT, S_ADDSUB, S_POW, S_PWAIT,
    S_CHK1, S_CHK2, S_SIGN, S_NEG, S_DONE
  } state_t;

  // Unpack the low 255 bits of the encoding straight into radix-2^25.5 limbs.
  function automatic logic [FE_W-1:0] fe_frombytes(input logic [254:0] b);
    logic [FE_W-1:0] f;
    int off;
    f = '0;
    off = 0;
    for (int i = 0; i < NL; i++) begin
      if (i % 2 == 0) begin
        f[32*i +: 32] = 32'((b >> off) & 255'h3ffffff);
        off += 26;
      end else begin
        f[32*i +: 32] = 32'((b >> off) & 255'h1ffffff);
        off += 25;
      end
    end
    return f;
  endfunction

  // Fully reduce to the canonical 255-bit value (ref10 fe_tobytes carry scheme).
  function automatic logic [255:0] fe_tobytes(input logic [FE_W-1:0] f);
    logic signed [31:0] h [NL];
    logic signed [31:0] q, c;
    logic [255:0] r;
    int sh, off;
    for (int i = 0; i < NL; i++) h[i] = f[32*i +: 32];
    q = (32'sd19 * h[NL-1] + 32'sd16777216) >>> 25;
    for (int i = 0; i < NL; i++) q = (h[i] + q) >>> ((i % 2 == 0) ? 26 : 25);
    h[0] = h[0] + 32'sd19 * q;
    for (int i = 0; i < NL - 1; i++) begin
      sh = (i % 2 == 0) ? 26 : 25;
      c = h[i] >>> sh;
      h[i+1] = h[i+1] + c;
      h[i] = h[i] - (c <<< sh);
    end
    c = h[NL-1] >>> 25;
    h[NL-1] = h[NL-1] - (c <<< 25);
    r = '0;
    off = 0;
    for (int i = 0; i < NL; i++) begin
      r = r | ({224'b0, h[i]} << off);
      off += (i % 2 == 0) ? 26 : 25;
    end
    return r;
  endfunction

  function automatic logic fe_isneg(input logic [FE_W-1:0] f);
    return |(fe_tobytes(f) & 256'd1);
  endfunction

  function automatic logic fe_isnz(input logic [FE_W-1:0] f);
    return |fe_tobytes(f);
  endfunction

  state_t          state_q;
  logic [3:0]      step_q;
  logic [WD_W-1:0] wdog_q;
  logic [255:0]    s_q;
  logic            neg_q;
  logic            ready_q, done_q, mul_valid_q, pow_valid_q;
  logic [1:0]      error_q;
  logic [FE_W-1:0] y_q, u_q, v_q, v3_q, x_q, vxx_q;
  logic [FE_W-1:0] h_x_q, h_y_q, h_z_q, h_t_q;
  logic [FE_W-1:0] mul_op_a_q, mul_op_b_q, pow_in_q;
  logic [FE_W-1:0] mul_a_d, mul_b_d, y_d, x_neg;
  logic            flip;

  assign y_d = fe_frombytes(s_q[254:0]);

  // Limb-wise negation; value is -x without any reduction.
  for (genvar i = 0; i < NL; i++) begin : g_neg
    assign x_neg[32*i +: 32] = 32'd0 - x_q[32*i +: 32];
  end

  // Sign fix-up: negate-vartime wants parity equal to the sign bit flipped.
  assign flip = neg_q ? (fe_isneg(x_q) == s_q[255]) : (fe_isneg(x_q) != s_q[255]);

  // Operand pair for the multiply step about to be issued.
  always_comb begin
    mul_a_d = x_q;
    mul_b_d = x_q;
    case (step_q)
      4'd0:  begin mul_a_d = y_q;   mul_b_d = y_q;          end
      4'd1:  begin mul_a_d = u_q;   mul_b_d = D_CONST;      end
      4'd2:  begin mul_a_d = v_q;   mul_b_d = v_q;          end
      4'd3:  begin mul_a_d = v3_q;  mul_b_d = v_q;          end
      4'd4:  begin mul_a_d = v3_q;  mul_b_d = v3_q;         end
      4'd5:  begin mul_a_d = x_q;   mul_b_d = v_q;          end
      4'd6:  begin mul_a_d = x_q;   mul_b_d = u_q;          end
      4'd7:  begin mul_a_d = x_q;   mul_b_d = v3_q;         end
      4'd8:  begin mul_a_d = x_q;   mul_b_d = u_q;          end
      4'd9:  begin mul_a_d = x_q;   mul_b_d = x_q;          end
      4'd10: begin mul_a_d = vxx_q; mul_b_d = v_q;          end
      4'd11: begin mul_a_d = x_q;   mul_b_d = SQRTM1_CONST; end
      default: begin mul_a_d = x_q; mul_b_d = y_q;          end
    endcase
  end

  // Add/sub units are combinational, so their operands follow the state directly.
  always_comb begin
    add_op_a_o = '0;
    add_op_b_o = '0;
    sub_op_a_o = '0;
    sub_op_b_o = '0;
    case (state_q)
      S_ADDSUB: begin
        sub_op_a_o = u_q;   sub_op_b_o = FE_ONE;
        add_op_a_o = v_q;   add_op_b_o = FE_ONE;
      end
      S_CHK1: begin sub_op_a_o = vxx_q; sub_op_b_o = u_q; end
      S_CHK2: begin add_op_a_o = vxx_q; add_op_b_o = u_q; end
      default: ;
    endcase
  end

  // Main sequencer: accept, issue/wait on shared units, check, fix sign, finish.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      step_q      <= '0;
      wdog_q      <= '0;
      s_q         <= '0;
      neg_q       <= 1'b0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= ERR_OK;
      mul_valid_q <= 1'b0;
      pow_valid_q <= 1'b0;
      y_q   <= '0; u_q  <= '0; v_q <= '0;
      v3_q  <= '0; x_q  <= '0; vxx_q <= '0;
      h_x_q <= '0; h_y_q <= '0; h_z_q <= '0; h_t_q <= '0;
      mul_op_a_q <= '0;
      mul_op_b_q <= '0;
      pow_in_q   <= '0;
    end else begin
      mul_valid_q <= 1'b0;
      pow_valid_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        S_IDLE: if (valid_i && ready_q) begin
          s_q     <= s_i;
          neg_q   <= negate_i;
          h_z_q   <= FE_ONE;
          error_q <= ERR_OK;
          ready_q <= 1'b0;
          state_q <= S_CAP;
        end
        S_CAP: begin
          y_q     <= y_d;
          h_y_q   <= y_d;
          step_q  <= 4'd0;
          state_q <= S_MUL;
        end
        S_MUL: begin
          mul_op_a_q  <= mul_a_d;
          mul_op_b_q  <= mul_b_d;
          mul_valid_q <= 1'b1;
          wdog_q      <= '0;
          state_q     <= S_MWAIT;
        end
        S_MWAIT: begin
          if (mul_done_i) begin
            step_q  <= step_q + 4'd1;
            state_q <= S_MUL;
            case (step_q)
              4'd0:       u_q <= mul_res_i;
              4'd1:       begin v_q <= mul_res_i; state_q <= S_ADDSUB; end
              4'd2, 4'd3: v3_q <= mul_res_i;
              4'd4, 4'd5: x_q <= mul_res_i;
              4'd6:       begin x_q <= mul_res_i; state_q <= S_POW; end
              4'd7, 4'd8: x_q <= mul_res_i;
              4'd9:       vxx_q <= mul_res_i;
              4'd10:      begin vxx_q <= mul_res_i; state_q <= S_CHK1; end
              4'd11:      begin x_q <= mul_res_i; state_q <= S_SIGN; end
              default: begin
                h_t_q   <= mul_res_i;
                h_x_q   <= x_q;
                error_q <= ERR_OK;
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end
            endcase
          end else if (wdog_q == MUL_LIM) begin
            error_q <= ERR_TO;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            wdog_q <= wdog_q + WD_W'(1);
          end
        end
        S_ADDSUB: begin
          u_q     <= sub_res_i;
          v_q     <= add_res_i;
          state_q <= S_MUL;
        end
        S_POW: begin
          pow_in_q    <= x_q;
          pow_valid_q <= 1'b1;
          wdog_q      <= '0;
          state_q     <= S_PWAIT;
        end
        S_PWAIT: begin
          if (pow_done_i) begin
            x_q     <= pow_res_i;
            step_q  <= 4'd7;
            state_q <= S_MUL;
          end else if (wdog_q == POW_LIM) begin
            error_q <= ERR_TO;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            wdog_q <= wdog_q + WD_W'(1);
          end
        end
        S_CHK1: state_q <= fe_isnz(sub_res_i) ? S_CHK2 : S_SIGN;
        S_CHK2: begin
          if (fe_isnz(add_res_i)) begin
            error_q <= ERR_CURVE;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            step_q  <= 4'd11;
            state_q <= S_MUL;
          end
        end
        S_SIGN: begin
          step_q  <= 4'd12;
          state_q <= flip ? S_NEG : S_MUL;
        end
        S_NEG: begin
          x_q     <= x_neg;
          state_q <= S_MUL;
        end
        S_DONE: begin
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ready_o     = ready_q;
  assign done_o      = done_q;
  assign error_o     = error_q;
  assign h_x_o       = h_x_q;
  assign h_y_o       = h_y_q;
  assign h_z_o       = h_z_q;
  assign h_t_o       = h_t_q;
  assign mul_op_a_o  = mul_op_a_q;
  assign mul_op_b_o  = mul_op_b_q;
  assign mul_valid_o = mul_valid_q;
  assign pow_in_o    = pow_in_q;
  assign pow_valid_o = pow_valid_q;

endmodule

// File: tb/tb_ge_frombytes_vartime_p.sv
// Bench for ge_frombytes_vartime_p: field units modelled with wide mod-p
// arithmetic, directed decompression vectors with known answers.
module tb_ge_frombytes_vartime_p;

  localparam int FE_W = 320;
  localparam int MUL_TIMEOUT = 1024;
  localparam logic [255:0] P  = (256'd1 << 255) - 256'd19;
  localparam logic [255:0] E  = (256'd1 << 252) - 256'd3;
  // Base point: encoding bytes 58 66 .. 66 little-endian, known x coordinate.
  localparam logic [255:0] BS = 256'h66666666_66666666_66666666_66666666_66666666_66666666_66666666_66666658;
  localparam logic [255:0] BX = 256'h216936d3_cd6e53fe_c0a4e231_fdd6dc5c_692cc760_9525a7b2_c9562d60_8f25d51a;

  logic clk, rst, valid, negate;
  logic [255:0] s;
  logic ready, done;
  logic [1:0] error;
  logic [FE_W-1:0] h_x, h_y, h_z, h_t;
  logic [FE_W-1:0] mul_op_a, mul_op_b, mul_res, add_op_a, add_op_b, add_res;
  logic [FE_W-1:0] sub_op_a, sub_op_b, sub_res, pow_in, pow_res;
  logic mul_valid, mul_done, pow_valid, pow_done;
  bit hold_mul;
  int n_chk = 0, n_err = 0;

  ge_frombytes_vartime_p #(.FE_W(FE_W), .MUL_TIMEOUT(MUL_TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .negate_i(negate), .s_i(s),
    .ready_o(ready), .done_o(done), .error_o(error),
    .h_x_o(h_x), .h_y_o(h_y), .h_z_o(h_z), .h_t_o(h_t),
    .mul_op_a_o(mul_op_a), .mul_op_b_o(mul_op_b), .mul_valid_o(mul_valid),
    .mul_res_i(mul_res), .mul_done_i(mul_done),
    .add_op_a_o(add_op_a), .add_op_b_o(add_op_b), .add_res_i(add_res),
    .sub_op_a_o(sub_op_a), .sub_op_b_o(sub_op_b), .sub_res_i(sub_res),
    .pow_in_o(pow_in), .pow_valid_o(pow_valid), .pow_res_i(pow_res), .pow_done_i(pow_done)
  );

  function automatic logic [255:0] modp(input logic [511:0] t);
    logic [511:0] r;
    r = t % {256'b0, P};
    return r[255:0];
  endfunction
  function automatic logic [255:0] fadd(input logic [255:0] a, input logic [255:0] b);
    return modp({256'b0, a} + {256'b0, b});
  endfunction
  function automatic logic [255:0] fsub(input logic [255:0] a, input logic [255:0] b);
    return modp({256'b0, a} + {256'b0, P} - {256'b0, b});
  endfunction
  function automatic logic [255:0] fmul(input logic [255:0] a, input logic [255:0] b);
    return modp({256'b0, a} * {256'b0, b});
  endfunction
  function automatic logic [255:0] fpow(input logic [255:0] a);
    logic [255:0] r;
    r = 256'd1;
    for (int i = 251; i >= 0; i--) begin
      r = fmul(r, r);
      if (E[i]) r = fmul(r, a);
    end
    return r;
  endfunction
  // Value of a signed-limb element, reduced mod p.
  function automatic logic [255:0] lval(input logic [FE_W-1:0] f);
    logic [255:0] acc, tm;
    logic [31:0] l, m;
    int off;
    acc = '0;
    off = 0;
    for (int i = 0; i < 10; i++) begin
      l = f[32*i +: 32];
      m = l[31] ? (32'd0 - l) : l;
      tm = modp({480'b0, m} << off);
      acc = l[31] ? fsub(acc, tm) : fadd(acc, tm);
      off += (i % 2 == 0) ? 26 : 25;
    end
    return acc;
  endfunction
  function automatic logic [FE_W-1:0] ltoe(input logic [255:0] v);
    logic [FE_W-1:0] f;
    logic [255:0] t;
    int off;
    f = '0;
    off = 0;
    for (int i = 0; i < 10; i++) begin
      t = v >> off;
      if (i % 2 == 0) begin f[32*i +: 32] = {6'b0, t[25:0]}; off += 26; end
      else            begin f[32*i +: 32] = {7'b0, t[24:0]}; off += 25; end
    end
    return f;
  endfunction

  task automatic chk(input string tag, input logic [FE_W-1:0] obs, input logic [FE_W-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  initial begin clk = 1'b0; forever #5 clk = ~clk; end
  initial begin #1_000_000; $display("FAIL global_timeout: run did not end"); $fatal(1); end

  always_comb add_res = ltoe(fadd(lval(add_op_a), lval(add_op_b)));
  always_comb sub_res = ltoe(fsub(lval(sub_op_a), lval(sub_op_b)));

  // Multiplier model: three-cycle latency, can be told to never answer.
  initial begin
    logic [FE_W-1:0] a, b;
    mul_done = 1'b0;
    mul_res = '0;
    forever begin
      @(negedge clk);
      if (mul_valid && !hold_mul) begin
        a = mul_op_a;
        b = mul_op_b;
        repeat (2) @(negedge clk);
        mul_res = ltoe(fmul(lval(a), lval(b)));
        mul_done = 1'b1;
        @(negedge clk);
        mul_done = 1'b0;
      end
    end
  end

  // pow22523 model: five-cycle latency.
  initial begin
    logic [FE_W-1:0] a;
    pow_done = 1'b0;
    pow_res = '0;
    forever begin
      @(negedge clk);
      if (pow_valid) begin
        a = pow_in;
        repeat (4) @(negedge clk);
        pow_res = ltoe(fpow(lval(a)));
        pow_done = 1'b1;
        @(negedge clk);
        pow_done = 1'b0;
      end
    end
  end

  task automatic start(input logic [255:0] sv, input logic ng);
    int n;
    n = 0;
    while (!ready && n < 100) begin @(negedge clk); n++; end
    valid = 1'b1; s = sv; negate = ng;
    @(negedge clk);
    valid = 1'b0;
    chk("ready_busy", ready, 0);
  endtask

  task automatic run(input logic [255:0] sv, input logic ng, input bit poke, output logic [1:0] err);
    int n;
    start(sv, ng);
    if (poke) begin
      repeat (3) @(negedge clk);
      chk("ready_mid", ready, 0);
      valid = 1'b1; s = 256'd1; negate = ~ng;
      @(negedge clk);
      valid = 1'b0;
    end
    n = 0;
    while (!done && n < 5000) begin @(negedge clk); n++; end
    if (!done) begin
      chk("done_seen", 0, 1);
      err = 2'b11;
    end else begin
      err = error;
      @(negedge clk);
      chk("done_pulse", done, 0);
      chk("ready_back", ready, 1);
    end
  endtask

  initial begin
    logic [1:0] err;
    logic [255:0] bt;
    int n, c;
    bit seen;
    bt = fmul(BX, BS);
    rst = 1'b1; valid = 1'b0; negate = 1'b0; s = '0; hold_mul = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_hx", h_x, 0);
    chk("rst_hz", h_z, 0);
    chk("rst_mulv", mul_valid, 0);
    chk("rst_powv", pow_valid, 0);
    chk("rst_mula", mul_op_a, 0);
    rst = 1'b0;
    @(negedge clk);

    // Identity point, then with sign bit in both modes.
    run(256'd1, 1'b0, 1'b0, err);
    chk("id_err", err, 0);
    chk("id_hx", lval(h_x), 0);
    chk("id_ht", lval(h_t), 0);
    chk("id_hy", lval(h_y), 1);
    chk("id_hz", h_z, 1);
    run(256'd1 | (256'd1 << 255), 1'b0, 1'b0, err);
    chk("id255_err", err, 0);
    chk("id255_hx", lval(h_x), 0);
    run(256'd1 | (256'd1 << 255), 1'b1, 1'b0, err);
    chk("id255n_err", err, 0);
    chk("id255n_hx", lval(h_x), 0);

    // Base point, plain rule.
    run(BS, 1'b0, 1'b0, err);
    chk("bp_err", err, 0);
    chk("bp_hx", lval(h_x), BX);
    chk("bp_hy", lval(h_y), BS);
    chk("bp_hz", h_z, 1);
    chk("bp_ht", lval(h_t), bt);

    // y=2 is not on the curve; coordinates from the base point must survive.
    run(256'd2, 1'b0, 1'b0, err);
    chk("off_err", err, 1);
    chk("off_hx", lval(h_x), BX);
    chk("off_ht", lval(h_t), bt);
    chk("off_hy", lval(h_y), 2);

    // Base point, negate rule, with a stray valid while busy.
    run(BS, 1'b1, 1'b1, err);
    chk("bpn_err", err, 0);
    chk("bpn_hx", lval(h_x), fsub(256'd0, BX));
    chk("bpn_ht", lval(h_t), fsub(256'd0, bt));

    // Multiplier never answers: timeout exactly MUL_TIMEOUT cycles after issue.
    hold_mul = 1'b1;
    start(256'd1, 1'b0);
    n = 0;
    while (!mul_valid && n < 100) begin @(negedge clk); n++; end
    chk("to_issue", mul_valid, 1);
    c = 0;
    while (!done && c < 5000) begin @(negedge clk); c++; end
    chk("to_latency", c, MUL_TIMEOUT);
    chk("to_err", error, 2);
    chk("to_hx", lval(h_x), fsub(256'd0, BX));
    @(negedge clk);
    chk("to_ready", ready, 1);
    hold_mul = 1'b0;
    run(BS, 1'b0, 1'b0, err);
    chk("after_to_err", err, 0);
    chk("after_to_hx", lval(h_x), BX);

    // Reset while waiting on pow.
    start(BS, 1'b0);
    n = 0;
    while (!pow_valid && n < 500) begin @(negedge clk); n++; end
    chk("pw_issue", pow_valid, 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("pr_ready", ready, 1);
    chk("pr_done", done, 0);
    chk("pr_error", error, 0);
    chk("pr_hx", h_x, 0);
    chk("pr_hy", h_y, 0);
    chk("pr_hz", h_z, 0);
    chk("pr_ht", h_t, 0);
    chk("pr_powin", pow_in, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (20) begin @(negedge clk); if (done) seen = 1'b1; end
    chk("pr_nodone", seen, 0);
    chk("pr_idle", ready, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ge_frombytes_vartime_p.md
Name: ge_frombytes_vartime_p

Overview:
- Parametrised Ed25519 point decompression: 32-byte encoding s in, extended point (X,Y,Z,T) out, in limb representation.
- Runtime mode selects the ref10 ge_frombytes sign rule or the ge_frombytes_negate_vartime sign rule.
- Shares external field resources: one multiplier, one add unit, one sub unit, and a pow22523 engine.
- Adds a ready/valid handshake, a 2-bit error code, parametrised constants and wait-state watchdogs.

Parameters:
- FE_W, 320: field-element width (10×32-bit limb representation as in fe_common).
- D_CONST, 320'hff480db4fee2b700ffce7199ffa03cbcff79e8980001c029006a0a0fff156ebd00d37285ff5978b6: curve constant d.
- SQRTM1_CONST, 320'h00ae0c920004fc1effe1656afe804c9ffffbd7a700bd0c600035697f008f189eff86c9d3fe0ea0b0: sqrt(-1).
- MUL_TIMEOUT, 1024: maximum cycles waiting on a single mul_done.
- POW_TIMEOUT, 65535: maximum cycles waiting on pow_done.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- valid  in  1  start request; accepted only when ready=1
- negate  in  1  sampled with valid; 1 = negate-vartime sign rule, 0 = plain frombytes rule
- s  in  256  encoded point; sampled with valid
- ready  out  1  high in IDLE
- done  out  1  one-cycle completion pulse
- error  out  2  0 = ok, 1 = not on curve, 2 = resource timeout; valid with done and held until next accept
- h_x, h_y, h_z, h_t  out  FE_W each  result coordinates; held until next accept
- mul_op_a, mul_op_b  out  FE_W  multiplier operands
- mul_valid  out  1  one-cycle issue pulse
- mul_res  in  FE_W  multiplier result
- mul_done  in  1  multiplier result strobe
- add_op_a, add_op_b  out  FE_W  add operands
- add_res  in  FE_W  combinational add result
- sub_op_a, sub_op_b  out  FE_W  sub operands
- sub_res  in  FE_W  combinational sub result
- pow_in  out  FE_W  pow22523 operand
- pow_valid  out  1  one-cycle pulse
- pow_res  in  FE_W  pow22523 result
- pow_done  in  1  pow22523 result strobe

Behaviour:
- Reset (async): state=IDLE; ready=1; done=0; error=0; h_x=h_y=h_t=0; h_z=0; all valid pulses=0; operand regs=0; watchdog=0.
- Accept: valid&&ready latches s and negate, and sets h_z=1. valid while busy is ignored.
- Capture: y = fe_frombytes(s), which masks bit 255. h_y gets y the cycle after accept.
- State sequence:
  - Multiplies, each one mul_valid pulse, then wait for mul_done: U=y·y; V=U·D; after V, combinational add/sub in one cycle gives u=U−1, v=V+1.
  - Further multiplies: v3=v·v; v3=v3·v; x=v3·v3; x=x·v; x=x·u.
  - POW: one pow_valid pulse, wait for pow_done, x=pow_res.
  - Then: x=x·v3; x=x·u; vxx=x·x; vxx=vxx·v.
  - CHK1: if (vxx−u)==0, go to SIGN.
  - CHK2: if (vxx+u)!=0, finish with error=1. Otherwise SQRT: x=x·SQRTM1, then SIGN.
  - SIGN: let b=s[255] and n=fe_isnegative(x). The flip condition is (negate ? n==b : n!=b). If it holds, x=fe_neg(x) one cycle later.
  - T: h_t=x·y. Finish with error=0.
- Finish: done pulses exactly one cycle and the block returns to IDLE that cycle, so ready=1 next cycle. h_x is written with the final x at finish. On error=1, h_x/h_t are not updated.
- Multiplier port: mul_op_a/b are stable from the mul_valid cycle until mul_done is sampled. mul_done arriving outside a wait state is ignored. At most one multiply is outstanding. The same rules apply to the pow port.
- Watchdog: counter clears on each mul_valid/pow_valid issue and increments every wait cycle. Reaching MUL_TIMEOUT (mul waits) or POW_TIMEOUT (pow wait) finishes with error=2, and the result regs are left unchanged. A late mul_done/pow_done after the timeout is ignored.
- mul_done in the same cycle the counter hits its limit: the result wins and there is no timeout.
- Same-cycle done and valid: valid is not accepted, because ready is 0 in the finish cycle.
- rst mid-operation: immediate return to IDLE with reset values. No done pulse.

Test Plan:
- Base point: s=0x5866666666666666666666666666666666666666666666666666666666666666, negate=0 → error=0; h_x is fe_frombytes(0x216936d3cd6e53fec0a4e231fdd6dc5c692cc7609525a7b2c9562d608f25d51a); h_z=1; h_t=x·y per C model.
- Same s with negate=1 → h_x equals fe_neg of the previous h_x, and h_t is negated.
- Identity: s=0x01 followed by zeros → error=0, h_x=0, h_t=0, h_y=1. Repeat with bit 255 set: h_x=0 in both modes.
- Off-curve: s with y=2 (C model reports −1) → done after CHK2 with error=1; h_x/h_t keep the previous values.
- Timeout: hold mul_done=0 after the first mul_valid → done with error=2 exactly MUL_TIMEOUT cycles later. A following valid is accepted and completes normally.
- Assert rst during the POW wait → ready=1 and all outputs at reset values immediately. No done pulse. valid asserted while busy is ignored.
